step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//   Controls pattern playback for the drum machine. Keeps the tempo (BPM up/down, clamped) and
//   derives the eighth-note period in ms with an on-chip serial divider. Fetches the 96-bit
//   pattern map from map storage over a req/ack handshake, steps through 32 slots on the 1 ms
//   tick, and sends one-cycle triggers carrying each slot's 3-bit sample code to the synth voice.
// PARAMETERS
//   STEPS     32    slots per pattern (power of 2)
//   CODE_W    3     bits per slot code; MAP_W = STEPS*CODE_W = 96
//   BPM_RST   140   tempo after reset
//   BPM_MIN   60    lower clamp
//   BPM_MAX   240   upper clamp
//   BPM_STEP  5     increment/decrement per button pulse
// PORTS
//   clk        in   1    system clock
//   nrst       in   1    asynchronous reset, active-low
//   tick_1ms   in   1    one-cycle pulse every 1 ms (from clock divider)
//   bpm_up     in   1    debounced one-cycle pulse: tempo += BPM_STEP
//   bpm_dn     in   1    debounced one-cycle pulse: tempo -= BPM_STEP
//   play       in   1    level; 1 = run, 0 = stop
//   sel_in     in   2    requested pattern number
//   map_req    out  1    map fetch request
//   map_sel    out  2    pattern number being fetched; stable while map_req=1
//   map_ack    in   1    map_data valid this cycle
//   map_data   in   96   pattern; slot n = map_data[3n+2:3n]
//   bpm        out  8    current tempo
//   period_ms  out  10   eighth-note length = floor(30000/bpm)
//   step       out  5    current slot index
//   trig       out  1    one-cycle strobe; slot code is non-zero
//   code       out  3    code of current slot; held until the next step
//   cur_sel    out  2    pattern number now loaded
// BEHAVIOUR
//   Reset values: bpm=BPM_RST, period_ms=214, step=0, trig=0, code=0, map_req=0, map_sel=0,
//     cur_sel=0, map register=0, state=IDLE, ms_cnt=0, divider idle.
//   Tempo: up and down pulses in the same cycle are ignored. bpm saturates at BPM_MIN/BPM_MAX.
//     A change starts a restoring divide of 30000 by bpm: 15 iterations, 1 per clk. period_ms
//     updates on completion; the done flag is internal.
//     A tempo change during a divide restarts the divide with the new bpm.
//     The step timer latches period_ms at each step start, so a new period applies from the next step.
//   FSM states: IDLE, FETCH, FIRE, RUN.
//   IDLE: step=0, code=0, ms_cnt=0. On play=1, latch sel_in into map_sel and go to FETCH.
//   FETCH: map_req=1 and map_sel held. In the first cycle with map_ack=1:
//     capture map_data, set cur_sel=map_sel, go to FIRE. map_req=0 from the next cycle.
//   FIRE (1 cycle): code <= slot[step]; trig <= (slot[step]!=0); ms_cnt <= 0;
//     latch period; go to RUN. trig is visible in the cycle after FIRE.
//   RUN: each tick_1ms increments ms_cnt.
//     On a tick with ms_cnt==period-1, step advances modulo STEPS (31 wraps to 0).
//     On a wrap where sel_in != cur_sel: map_sel<=sel_in, go to FETCH, step 0 fires after ack.
//     Otherwise go to FIRE.
//   sel_in changes are applied only at the 31->0 wrap, never mid-bar.
//   play=0 in any state: next cycle goes to IDLE, map_req=0, trig=0, step=0. A pending fetch is abandoned.
//   Async reset at any time, including mid-fetch or mid-divide, returns all reset values at once.
//   Steps are evenly spaced: trig-to-trig = period_ms ticks (+2 clk for FIRE).
//     The first step after play also includes the fetch latency.
//   Tempo pulses are accepted in every state, including IDLE.
// TESTING
//   1. Reset, play=1, map_ack after 3 clk, slot0=3'd5 -> map_req is 1 for 4 cycles, trig+code=5.
//      Slot1 fires 214 ticks later.
//   2. Map with slot2=0 -> no trig at step 2, code=0, step still advances; step 31 wraps to 0.
//   3. Ten bpm_up from 140 -> bpm 190, then period_ms=157 within 16 clk.
//      Twenty more bpm_up -> bpm clamps at 240, period_ms=125.
//   4. bpm_up and bpm_dn in the same cycle -> bpm unchanged, no divide.
//      bpm_dn during an active divide -> final period_ms matches the last bpm.
//   5. sel_in 0->2 at step 10 -> no fetch until the 31->0 wrap.
//      Then map_req with map_sel=2, cur_sel=2, step 0 uses the new map.
//   6. play=0 mid-FETCH -> map_req drops the next cycle, IDLE, step=0.
//      nrst pulse mid-divide -> bpm=140, period_ms=214.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer
//   Pattern playback controller for the drum machine. Holds the tempo
//   (BPM up/down with clamping), derives the eighth-note period in ms
//   with a serial restoring divider (30000 / bpm), fetches a pattern map
//   over a req/ack handshake and walks its slots on the 1 ms tick, firing
//   a one-cycle trigger with the slot's sample code for every non-zero slot.
//
// Ports
//   clk          system clock
//   nrst         asynchronous reset, active-low
//   tick_1ms_i   one-cycle pulse every 1 ms
//   bpm_up_i     one-cycle pulse: tempo += BPM_STEP
//   bpm_dn_i     one-cycle pulse: tempo -= BPM_STEP
//   play_i       level: 1 = run, 0 = stop
//   sel_in_i     requested pattern number
//   map_req_o    map fetch request
//   map_sel_o    pattern number being fetched (stable while map_req_o=1)
//   map_ack_i    map_data_i valid this cycle
//   map_data_i   pattern map, slot n = map_data_i[CODE_W*n +: CODE_W]
//   bpm_o        current tempo
//   period_ms_o  eighth-note length, floor(30000 / bpm)
//   step_o       current slot index
//   trig_o       one-cycle strobe for a non-zero slot
//   code_o       code of the current slot, held until the next step
//   cur_sel_o    pattern number currently loaded
module step_sequencer #(
    parameter int STEPS    = 32,
    parameter int CODE_W   = 3,
    parameter int BPM_RST  = 140,
    parameter int BPM_MIN  = 60,
    parameter int BPM_MAX  = 240,
    parameter int BPM_STEP = 5,
    localparam int MAP_W   = STEPS * CODE_W,
    localparam int STEP_W  = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              tick_1ms_i,
    input  logic              bpm_up_i,
    input  logic              bpm_dn_i,
    input  logic              play_i,
    input  logic [1:0]        sel_in_i,
    output logic              map_req_o,
    output logic [1:0]        map_sel_o,
    input  logic              map_ack_i,
    input  logic [MAP_W-1:0]  map_data_i,
    output logic [7:0]        bpm_o,
    output logic [9:0]        period_ms_o,
    output logic [STEP_W-1:0] step_o,
    output logic              trig_o,
    output logic [CODE_W-1:0] code_o,
    output logic [1:0]        cur_sel_o
);

    localparam int             DIV_W      = 15;
    localparam int             DIVIDEND   = 30000;
    localparam int             PERIOD_RST = DIVIDEND / BPM_RST;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FIRE, S_RUN} state_t;

    // Tempo and divider state
    logic [7:0]       bpm_q, bpm_d;
    logic [9:0]       period_q;
    logic             div_busy_q;
    logic [3:0]       div_cnt_q;
    logic [8:0]       div_rem_q, div_rem_d;
    logic [DIV_W-1:0] div_dvd_q;
    logic [9:0]       div_quo_q, div_quo_d;
    logic [9:0]       div_trial;
    logic             div_qbit;

    // Playback state
    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic              trig_q;
    logic [CODE_W-1:0] code_q;
    logic              map_req_q;
    logic [1:0]        map_sel_q;
    logic [1:0]        cur_sel_q;
    logic [MAP_W-1:0]  map_q;
    logic [9:0]        ms_cnt_q;
    logic [9:0]        per_lat_q;
    logic [CODE_W-1:0] slot_code;

    // Simultaneous up/down cancels; both directions saturate at the clamps.
    always_comb begin
        bpm_d = bpm_q;
        if (bpm_up_i && !bpm_dn_i) begin
            if (({1'b0, bpm_q} + 9'(BPM_STEP)) > 9'(BPM_MAX))
                bpm_d = 8'(BPM_MAX);
            else
                bpm_d = bpm_q + 8'(BPM_STEP);
        end else if (bpm_dn_i && !bpm_up_i) begin
            if (bpm_q < 8'(BPM_MIN + BPM_STEP))
                bpm_d = 8'(BPM_MIN);
            else
                bpm_d = bpm_q - 8'(BPM_STEP);
        end
    end

    // One restoring-division iteration: bring down the next dividend bit,
    // subtract the divisor if it fits. The remainder stays below bpm (<= 240),
    // and the quotient never exceeds 500, so 9/10-bit registers suffice.
    always_comb begin
        div_trial = {div_rem_q, div_dvd_q[DIV_W-1]};
        if (div_trial >= {2'b00, bpm_q}) begin
            div_rem_d = 9'(div_trial - {2'b00, bpm_q});
            div_qbit  = 1'b1;
        end else begin
            div_rem_d = div_trial[8:0];
            div_qbit  = 1'b0;
        end
        div_quo_d = {div_quo_q[8:0], div_qbit};
    end

    // A tempo change (re)starts the divide against the new bpm; period_q
    // only moves when all 15 iterations have completed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bpm_q      <= 8'(BPM_RST);
            period_q   <= 10'(PERIOD_RST);
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_dvd_q  <= '0;
            div_quo_q  <= '0;
        end else if (bpm_d != bpm_q) begin
            bpm_q      <= bpm_d;
            div_busy_q <= 1'b1;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_dvd_q  <= DIV_W'(DIVIDEND);
            div_quo_q  <= '0;
        end else if (div_busy_q) begin
            div_rem_q <= div_rem_d;
            div_dvd_q <= {div_dvd_q[DIV_W-2:0], 1'b0};
            div_quo_q <= div_quo_d;
            div_cnt_q <= div_cnt_q + 4'd1;
            if (div_cnt_q == 4'(DIV_W - 1)) begin
                div_busy_q <= 1'b0;
                period_q   <= div_quo_d;
            end
        end
    end

    assign slot_code = map_q[int'(step_q) * CODE_W +: CODE_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            trig_q    <= 1'b0;
            code_q    <= '0;
            map_req_q <= 1'b0;
            map_sel_q <= '0;
            cur_sel_q <= '0;
            map_q     <= '0;
            ms_cnt_q  <= '0;
            per_lat_q <= 10'(PERIOD_RST);
        end else if (!play_i) begin
            // Stop wins in every state, abandoning any fetch in flight.
            state_q   <= S_IDLE;
            step_q    <= '0;
            trig_q    <= 1'b0;
            code_q    <= '0;
            map_req_q <= 1'b0;
            ms_cnt_q  <= '0;
        end else begin
            trig_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    map_sel_q <= sel_in_i;
                    map_req_q <= 1'b1;
                    state_q   <= S_FETCH;
                end
                S_FETCH: begin
                    if (map_ack_i) begin
                        map_q     <= map_data_i;
                        cur_sel_q <= map_sel_q;
                        map_req_q <= 1'b0;
                        state_q   <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    // The period is sampled here, so a tempo change only
                    // stretches or shrinks the following step.
                    code_q    <= slot_code;
                    trig_q    <= (slot_code != '0);
                    ms_cnt_q  <= '0;
                    per_lat_q <= period_q;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (tick_1ms_i) begin
                        if (ms_cnt_q == per_lat_q - 10'd1) begin
                            ms_cnt_q <= '0;
                            step_q   <= step_q + STEP_W'(1);
                            // Pattern changes are only honoured at the bar line.
                            if (step_q == STEP_W'(STEPS - 1) && sel_in_i != cur_sel_q) begin
                                map_sel_q <= sel_in_i;
                                map_req_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end else begin
                                state_q <= S_FIRE;
                            end
                        end else begin
                            ms_cnt_q <= ms_cnt_q + 10'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign map_req_o   = map_req_q;
    assign map_sel_o   = map_sel_q;
    assign bpm_o       = bpm_q;
    assign period_ms_o = period_q;
    assign step_o      = step_q;
    assign trig_o      = trig_q;
    assign code_o      = code_q;
    assign cur_sel_o   = cur_sel_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        tick_1ms_i;
    logic        bpm_up_i;
    logic        bpm_dn_i;
    logic        play_i;
    logic [1:0]  sel_in_i;
    logic        map_req_o;
    logic [1:0]  map_sel_o;
    logic        map_ack_i;
    logic [95:0] map_data_i;
    logic [7:0]  bpm_o;
    logic [9:0]  period_ms_o;
    logic [4:0]  step_o;
    logic        trig_o;
    logic [2:0]  code_o;
    logic [1:0]  cur_sel_o;

    step_sequencer dut (
        .clk         (clk),
        .nrst        (nrst),
        .tick_1ms_i  (tick_1ms_i),
        .bpm_up_i    (bpm_up_i),
        .bpm_dn_i    (bpm_dn_i),
        .play_i      (play_i),
        .sel_in_i    (sel_in_i),
        .map_req_o   (map_req_o),
        .map_sel_o   (map_sel_o),
        .map_ack_i   (map_ack_i),
        .map_data_i  (map_data_i),
        .bpm_o       (bpm_o),
        .period_ms_o (period_ms_o),
        .step_o      (step_o),
        .trig_o      (trig_o),
        .code_o      (code_o),
        .cur_sel_o   (cur_sel_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic tick_en = 1'b0;
    int tick_cnt = 0;

    typedef struct {
        int step;
        int code;
        int gap;   // ticks since previous trigger, -1 = not checked
    } trig_t;
    trig_t sb_q[$];
    trig_t sb_e;

    typedef struct {
        logic up;
        logic dn;
        int   bpm;
        int   period;
    } tvec_t;
    tvec_t tv[$];

    logic [95:0] map_a;
    logic [95:0] map_b;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int code_a(input int n);
        if (n == 0) return 5;
        if (n == 2) return 0;
        return (n % 7) + 1;
    endfunction

    function automatic int code_b(input int n);
        return 7 - (n % 7);
    endfunction

    // 1 ms tick every third clock, launched just after a rising edge.
    initial begin
        tick_1ms_i = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 tick_1ms_i = tick_en;
            @(posedge clk);
            #1 tick_1ms_i = 1'b0;
        end
    end

    // Trigger scoreboard: each observed strobe is matched against the next
    // expected slot, including its distance in ticks from the previous one.
    always @(negedge clk) begin
        if (trig_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_trig", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("trig_step", int'(step_o), sb_e.step);
                chk("trig_code", int'(code_o), sb_e.code);
                if (sb_e.gap >= 0) chk("trig_gap", tick_cnt, sb_e.gap);
            end
            tick_cnt = 0;
        end
        if (tick_1ms_i) tick_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (map_req_o) break;
        end
        chk(nm, int'(map_req_o), 1);
    endtask

    task automatic wait_step(input int s, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(step_o) == s) break;
        end
        chk(nm, int'(step_o), s);
    endtask

    task automatic wait_sb_empty(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk(nm, sb_q.size(), 0);
    endtask

    task automatic push_map_a(input int p);
        int prev;
        prev = -1;
        for (int s = 0; s < 32; s++) begin
            if (code_a(s) != 0) begin
                sb_q.push_back('{s, code_a(s), (prev < 0) ? -1 : (s - prev) * p});
                prev = s;
            end
        end
    endtask

    initial begin
        int m;
        int req_cnt;

        for (int n = 0; n < 32; n++) begin
            map_a[n*3 +: 3] = 3'(code_a(n));
            map_b[n*3 +: 3] = 3'(code_b(n));
        end

        // Tempo vectors: 10 up, cancelling pair, 20 up (clamps), 40 down
        // (clamps), 36 up back to the top.
        m = 140;
        for (int i = 0; i < 10; i++) begin
            m = (m + 5 > 240) ? 240 : m + 5;
            tv.push_back('{1'b1, 1'b0, m, 30000 / m});
        end
        tv.push_back('{1'b1, 1'b1, m, 30000 / m});
        for (int i = 0; i < 20; i++) begin
            m = (m + 5 > 240) ? 240 : m + 5;
            tv.push_back('{1'b1, 1'b0, m, 30000 / m});
        end
        for (int i = 0; i < 40; i++) begin
            m = (m - 5 < 60) ? 60 : m - 5;
            tv.push_back('{1'b0, 1'b1, m, 30000 / m});
        end
        for (int i = 0; i < 36; i++) begin
            m = (m + 5 > 240) ? 240 : m + 5;
            tv.push_back('{1'b1, 1'b0, m, 30000 / m});
        end

        nrst       = 1'b0;
        bpm_up_i   = 1'b0;
        bpm_dn_i   = 1'b0;
        play_i     = 1'b0;
        sel_in_i   = 2'd0;
        map_ack_i  = 1'b0;
        map_data_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_bpm",     int'(bpm_o), 140);
        chk("rst_period",  int'(period_ms_o), 214);
        chk("rst_step",    int'(step_o), 0);
        chk("rst_trig",    int'(trig_o), 0);
        chk("rst_code",    int'(code_o), 0);
        chk("rst_map_req", int'(map_req_o), 0);
        chk("rst_map_sel", int'(map_sel_o), 0);
        chk("rst_cur_sel", int'(cur_sel_o), 0);
        nrst = 1'b1;
        @(negedge clk);

        // Start playback, acknowledge on the fourth request cycle.
        tick_en = 1'b1;
        sel_in_i = 2'd0;
        play_i = 1'b1;
        sb_q.push_back('{0, 5, -1});
        sb_q.push_back('{1, 2, 214});
        wait_req(10, "t1_req_rise");
        req_cnt = 1;
        repeat (3) begin
            @(negedge clk);
            if (map_req_o) req_cnt++;
        end
        chk("t1_map_sel", int'(map_sel_o), 0);
        map_data_i = map_a;
        map_ack_i  = 1'b1;
        @(negedge clk);
        map_ack_i  = 1'b0;
        chk("t1_req_after_ack", int'(map_req_o), 0);
        chk("t1_req_cycles", req_cnt, 4);
        wait_sb_empty(214 * 3 + 100, "t1_two_trigs");
        play_i = 1'b0;
        @(negedge clk);
        chk("t1_stop_step", int'(step_o), 0);
        chk("t1_stop_trig", int'(trig_o), 0);

        // Tempo table, applied while stopped.
        foreach (tv[i]) begin
            bpm_up_i = tv[i].up;
            bpm_dn_i = tv[i].dn;
            @(negedge clk);
            bpm_up_i = 1'b0;
            bpm_dn_i = 1'b0;
            repeat (16) @(negedge clk);
            chk("tv_bpm", int'(bpm_o), tv[i].bpm);
            chk("tv_period", int'(period_ms_o), tv[i].period);
        end

        // Second down pulse lands mid-divide; result must follow 230.
        bpm_dn_i = 1'b1;
        @(negedge clk);
        bpm_dn_i = 1'b0;
        repeat (3) @(negedge clk);
        bpm_dn_i = 1'b1;
        @(negedge clk);
        bpm_dn_i = 1'b0;
        repeat (16) @(negedge clk);
        chk("restart_bpm", int'(bpm_o), 230);
        chk("restart_period", int'(period_ms_o), 130);
        repeat (2) begin
            bpm_up_i = 1'b1;
            @(negedge clk);
            bpm_up_i = 1'b0;
            @(negedge clk);
        end
        repeat (16) @(negedge clk);
        chk("back_bpm", int'(bpm_o), 240);
        chk("back_period", int'(period_ms_o), 125);

        // Full bar at 125 ms with a silent slot 2 and a pattern request mid-bar.
        sel_in_i = 2'd0;
        play_i = 1'b1;
        push_map_a(125);
        wait_req(10, "t2_req_rise");
        chk("t2_map_sel", int'(map_sel_o), 0);
        map_data_i = map_a;
        map_ack_i  = 1'b1;
        @(negedge clk);
        map_ack_i  = 1'b0;
        wait_step(2, 125 * 3 * 3, "t2_reach_step2");
        repeat (3) @(negedge clk);
        chk("t2_silent_code", int'(code_o), 0);
        wait_step(10, 125 * 3 * 10, "t5_reach_step10");
        sel_in_i = 2'd2;
        wait_req(125 * 3 * 24, "t5_fetch_req");
        chk("t5_fetch_at_wrap", int'(step_o), 0);
        chk("t5_bar_done", sb_q.size(), 0);
        chk("t5_map_sel", int'(map_sel_o), 2);
        sb_q.push_back('{0, 7, -1});
        sb_q.push_back('{1, 6, 125});
        repeat (2) @(negedge clk);
        map_data_i = map_b;
        map_ack_i  = 1'b1;
        @(negedge clk);
        map_ack_i  = 1'b0;
        chk("t5_cur_sel", int'(cur_sel_o), 2);
        wait_sb_empty(125 * 3 * 2 + 100, "t5_new_map_trigs");

        // Stop during a fetch.
        play_i = 1'b0;
        repeat (2) @(negedge clk);
        play_i = 1'b1;
        wait_req(10, "t6_req_rise");
        play_i = 1'b0;
        @(negedge clk);
        chk("t6_req_dropped", int'(map_req_o), 0);
        chk("t6_step", int'(step_o), 0);
        chk("t6_trig", int'(trig_o), 0);

        // Asynchronous reset in the middle of a divide.
        bpm_dn_i = 1'b1;
        @(negedge clk);
        bpm_dn_i = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("t6_rst_bpm", int'(bpm_o), 140);
        chk("t6_rst_period", int'(period_ms_o), 214);
        chk("t6_rst_cur_sel", int'(cur_sel_o), 0);
        chk("t6_rst_map_sel", int'(map_sel_o), 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_post_bpm", int'(bpm_o), 140);
        chk("t6_post_period", int'(period_ms_o), 214);

        tick_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
